// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deframes 11-bit frames,
// and decodes WASD make/break scancodes into a held USB HID keycode.
module ps2_keycode #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       keycode_chg,
    output logic       frame_err
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic             clk_s1, clk_s2, clk_prev;
    logic             dat_s1, dat_s2;
    logic             fall;
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             byte_vld_q, byte_vld_d;
    logic [7:0]       byte_q, byte_d;
    logic             flush_q, flush_d;
    logic             err_d;
    logic             brk_q, ext_q;
    logic [7:0]       hid_c;

    // Two-flop synchronizers plus one more stage on the clock for edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            idle_q     <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            flush_q    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            idle_q     <= idle_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            flush_q    <= flush_d;
            frame_err  <= err_d;
        end
    end

    // Frame FSM; a timeout takes priority over a coincident falling edge
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        idle_d     = '0;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        flush_d    = 1'b0;
        err_d      = 1'b0;
        if (state_q != S_IDLE) begin
            idle_d = fall ? '0 : idle_q + CNT_W'(1);
        end
        if (state_q != S_IDLE && idle_q == TO_LAST) begin
            state_d   = S_IDLE;
            idle_d    = '0;
            shift_d   = '0;
            bit_cnt_d = '0;
            err_d     = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s2;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if ((^{shift_q, par_q}) && dat_s2) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        err_d   = 1'b1;
                        flush_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Scancode set 2 to HID for the movement keys; 0 means unmapped
    always_comb begin
        hid_c = 8'h00;
        case (byte_q)
            8'h1C:   hid_c = 8'h04;
            8'h23:   hid_c = 8'h07;
            8'h1B:   hid_c = 8'h16;
            8'h1D:   hid_c = 8'h1A;
            default: hid_c = 8'h00;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            keycode     <= 8'h00;
            keycode_chg <= 1'b0;
        end else begin
            keycode_chg <= 1'b0;
            if (flush_q) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end else if (byte_vld_q) begin
                if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                    if (!ext_q && hid_c != 8'h00) begin
                        if (!brk_q) begin
                            keycode     <= hid_c;
                            keycode_chg <= (hid_c != keycode);
                        end else if (keycode == hid_c) begin
                            keycode     <= 8'h00;
                            keycode_chg <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: a scancode-level model predicts keycode and pulse counts per frame.
module tb_ps2_keycode;

    localparam int unsigned TO = 100;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keycode;
    logic       keycode_chg;
    logic       frame_err;

    ps2_keycode #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .keycode(keycode), .keycode_chg(keycode_chg), .frame_err(frame_err)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int chg_cnt = 0;
    int err_cnt = 0;
    logic [7:0] kc_prev = 8'h00;

    logic [7:0] m_kc = 8'h00;
    bit m_brk = 1'b0;
    bit m_ext = 1'b0;
    int m_chg = 0;
    int m_err = 0;

    // Every cycle: keycode_chg must be high exactly when keycode differs from last cycle
    always @(posedge Clk) begin
        #1;
        if (!Reset_n) begin
            kc_prev = keycode;
        end else begin
            tests++;
            if (keycode_chg !== (keycode != kc_prev)) begin
                fails++;
                $display("FAIL chg_rule t=%0t: keycode_chg=%b keycode=%h previous=%h", $time, keycode_chg, keycode, kc_prev);
            end
            if (keycode_chg) chg_cnt++;
            if (frame_err) err_cnt++;
            kc_prev = keycode;
        end
    end

    function automatic logic [7:0] hid(input logic [7:0] sc);
        case (sc)
            8'h1C:   return 8'h04;
            8'h23:   return 8'h07;
            8'h1B:   return 8'h16;
            8'h1D:   return 8'h1A;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] h;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            h = hid(b);
            if (!m_ext && h != 8'h00) begin
                if (!m_brk) begin
                    if (m_kc != h) m_chg++;
                    m_kc = h;
                end else if (m_kc == h) begin
                    m_kc = 8'h00;
                    m_chg++;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge Clk);
        ps2_dat = b;
        repeat (4) @(negedge Clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge Clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_counts(input string name);
        check({name, "_keycode"}, int'(keycode), int'(m_kc));
        check({name, "_chg_pulses"}, chg_cnt, m_chg);
        check({name, "_err_pulses"}, err_cnt, m_err);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string name);
        logic par;
        chg_cnt = 0;
        err_cnt = 0;
        m_chg = 0;
        m_err = 0;
        par = ~(^b);
        if (bad_par) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(bad_stop ? 1'b0 : 1'b1);
        ps2_dat = 1'b1;
        repeat (20) @(negedge Clk);
        if (bad_par || bad_stop) begin
            m_err = 1;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            model_byte(b);
        end
        check_counts(name);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_keycode", int'(keycode), 0);
        check("reset_chg", int'(keycode_chg), 0);
        check("reset_err", int'(frame_err), 0);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        frame(8'h1D, 0, 0, "w_make");
        check("lit_w", int'(keycode), 8'h1A);
        frame(8'hF0, 0, 0, "f0");
        frame(8'h1D, 0, 0, "w_break");

        frame(8'h1C, 0, 0, "a_make");
        check("lit_a", int'(keycode), 8'h04);
        frame(8'hF0, 0, 0, "f0");
        frame(8'h1C, 0, 0, "a_break");
        check("lit_a_rel", int'(keycode), 8'h00);

        frame(8'h1D, 1, 0, "w_badpar");
        check("lit_badpar_kc", int'(keycode), 8'h00);
        frame(8'h1B, 0, 0, "s_after_err");
        check("lit_s", int'(keycode), 8'h16);

        frame(8'h23, 0, 0, "d_make");
        check("lit_d", int'(keycode), 8'h07);
        frame(8'h1B, 0, 0, "s_make");
        frame(8'hF0, 0, 0, "f0");
        frame(8'h23, 0, 0, "d_break_other");
        check("lit_s_kept", int'(keycode), 8'h16);

        // A frame error between F0 and the scancode drops the break prefix
        frame(8'hF0, 0, 0, "f0");
        frame(8'h1B, 1, 0, "s_badpar");
        frame(8'h1B, 0, 0, "s_make_after_flush");
        check("lit_s_flush", int'(keycode), 8'h16);
        frame(8'h1C, 0, 1, "a_badstop");

        chg_cnt = 0;
        err_cnt = 0;
        m_chg = 0;
        m_err = 1;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 50) @(negedge Clk);
        check_counts("timeout");
        frame(8'h1C, 0, 0, "a_after_timeout");
        check("lit_a_timeout", int'(keycode), 8'h04);

        frame(8'hE0, 0, 0, "e0");
        frame(8'h1D, 0, 0, "ext_w_ignored");
        check("lit_ext", int'(keycode), 8'h04);
        frame(8'h1D, 0, 0, "w_make2");
        frame(8'h1D, 0, 0, "w_repeat");
        frame(8'h1D, 0, 0, "w_repeat2");
        check("lit_repeat", int'(keycode), 8'h1A);

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("midreset_keycode", int'(keycode), 0);
        check("midreset_chg", int'(keycode_chg), 0);
        check("midreset_err", int'(frame_err), 0);
        m_kc = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        frame(8'h1C, 0, 0, "a_after_reset");
        check("lit_a_reset", int'(keycode), 8'h04);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
